// File: rtl/sum_bcd_split.sv
// Sequential binary-to-BCD converter: captures a 16-bit sum on start and
// converts it by double dabble over 16 cycles into five packed BCD digits.
module sum_bcd_split (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd
);

    localparam int unsigned BIN_W    = 16;
    localparam int unsigned DIGITS   = 5;
    localparam int unsigned BCD_W    = 4 * DIGITS;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned CNT_LAST = BIN_W - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_d;
    logic               busy_d, done_d;

    logic [BCD_W-1:0]         adj_c;
    logic [BCD_W+BIN_W-1:0]   shifted_c;

    // Add-3 correction on every digit that would overflow past 9 when doubled
    always_comb begin
        adj_c = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj_c[4*i +: 4] = scratch_q[4*i +: 4]
                            + ((scratch_q[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
        end
    end

    assign shifted_c = {adj_c, shift_q} << 1;

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    shift_d   = bin;
                    scratch_d = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = S_SHIFT;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_SHIFT: begin
                scratch_d = shifted_c[BCD_W+BIN_W-1:BIN_W];
                shift_d   = shifted_c[BIN_W-1:0];
                cnt_d     = cnt_q + CNT_W'(1);
                busy_d    = 1'b1;
                if (cnt_q == CNT_W'(CNT_LAST)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    bcd_d   = shifted_c[BCD_W+BIN_W-1:BIN_W];
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd       <= bcd_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule
